// File: rtl/smpl_mem_arbiter.sv
// Three-way single-port memory arbiter: debug > fetch/data (round-robin), with a
// limit on consecutive debug grants while fetch or data is waiting.
module smpl_mem_arbiter #(
   parameter int unsigned DBG_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        halt_i,
   input  logic        f_req_i,
   input  logic [12:0] f_addr_i,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [12:0] d_addr_i,
   input  logic [15:0] d_wdata_i,
   input  logic        g_req_i,
   input  logic        g_we_i,
   input  logic [12:0] g_addr_i,
   input  logic [15:0] g_wdata_i,
   output logic        f_gnt_o,
   output logic        d_gnt_o,
   output logic        g_gnt_o,
   output logic        f_rvalid_o,
   output logic        d_rvalid_o,
   output logic        g_rvalid_o,
   output logic [15:0] rdata_o,
   output logic [12:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   output logic        mem_re_o,
   output logic        mem_we_o,
   input  logic [15:0] mem_rdata_i
);

   localparam int unsigned CntW = ($clog2(DBG_LIMIT + 1) > 3) ? $clog2(DBG_LIMIT + 1) : 3;

   logic            rr_q, rr_d;  // 1: data favoured on the next f/d conflict
   logic [CntW-1:0] dbg_cnt_q, dbg_cnt_d;
   logic            f_rvalid_q, d_rvalid_q, g_rvalid_q;
   logic            fd_wait, dbg_force;

   assign fd_wait   = f_req_i | d_req_i;
   assign dbg_force = fd_wait && (dbg_cnt_q >= CntW'(DBG_LIMIT));

   always_comb begin
      f_gnt_o = 1'b0;
      d_gnt_o = 1'b0;
      g_gnt_o = 1'b0;
      if (!halt_i && !reset) begin
         if (g_req_i && !dbg_force) begin
            g_gnt_o = 1'b1;
         end else if (f_req_i && d_req_i) begin
            if (rr_q) d_gnt_o = 1'b1;
            else      f_gnt_o = 1'b1;
         end else if (f_req_i) begin
            f_gnt_o = 1'b1;
         end else if (d_req_i) begin
            d_gnt_o = 1'b1;
         end
      end
   end

   always_comb begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_we_o    = 1'b0;
      if (g_gnt_o) begin
         mem_addr_o  = g_addr_i;
         mem_wdata_o = g_wdata_i;
         mem_we_o    = g_we_i;
      end else if (d_gnt_o) begin
         mem_addr_o  = d_addr_i;
         mem_wdata_o = d_wdata_i;
         mem_we_o    = d_we_i;
      end else if (f_gnt_o) begin
         mem_addr_o  = f_addr_i;
      end
      mem_re_o = (f_gnt_o | d_gnt_o | g_gnt_o) & ~mem_we_o;
   end

   always_comb begin
      rr_d      = rr_q;
      dbg_cnt_d = dbg_cnt_q;
      if (f_gnt_o) begin
         rr_d      = 1'b1;
         dbg_cnt_d = '0;
      end else if (d_gnt_o) begin
         rr_d      = 1'b0;
         dbg_cnt_d = '0;
      end else if (!halt_i && !fd_wait) begin
         dbg_cnt_d = '0;
      end else if (g_gnt_o) begin
         dbg_cnt_d = dbg_cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_q       <= 1'b0;
         dbg_cnt_q  <= '0;
         f_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         g_rvalid_q <= 1'b0;
      end else begin
         rr_q       <= rr_d;
         dbg_cnt_q  <= dbg_cnt_d;
         f_rvalid_q <= f_gnt_o;
         d_rvalid_q <= d_gnt_o & ~d_we_i;
         g_rvalid_q <= g_gnt_o & ~g_we_i;
      end
   end

   assign f_rvalid_o = f_rvalid_q;
   assign d_rvalid_o = d_rvalid_q;
   assign g_rvalid_o = g_rvalid_q;
   assign rdata_o    = (f_rvalid_q | d_rvalid_q | g_rvalid_q) ? mem_rdata_i : 16'h0000;

endmodule
